// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: control bundle between the multi-cycle main control FSM and
// the datapath it steers.
//   master : control FSM side (reads opcode/mem_ready, drives all controls)
//   slave  : datapath side (drives opcode/mem_ready, reads all controls)
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main control unit of the multi-cycle MIPS-subset core.
// Walks fetch/decode/execute/memory/write-back one instruction at a time and
// decodes every datapath enable and mux select from the current state.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (forces state to FETCH, outputs to 0)
//   bus  - mc_control_fsm_if.master: opcode/mem_ready in, controls + state out
// Build option:
//   MC_CTRL_JUMP_EN - when defined, opcode 000010 (j) executes through the
//                     JUMP state; when undefined it is flagged as illegal.
module mc_control_fsm (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;

  // Next state and Moore-style control decode. Only FETCH/MEMRD/MEMWR look at
  // mem_ready, and only DECODE/MEMADR look at opcode.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC only load on the cycle the read actually completes.
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally so no strobe escapes in the reset
  // cycle, even before the state register has been cleared by an edge.
  assign bus.pc_write      = !rst && pc_write;
  assign bus.pc_write_cond = !rst && pc_write_cond;
  assign bus.pc_source     = rst ? 2'b00 : pc_source;
  assign bus.iord          = !rst && iord;
  assign bus.mem_read      = !rst && mem_read;
  assign bus.mem_write     = !rst && mem_write;
  assign bus.ir_write      = !rst && ir_write;
  assign bus.reg_dst       = !rst && reg_dst;
  assign bus.mem_to_reg    = !rst && mem_to_reg;
  assign bus.reg_write     = !rst && reg_write;
  assign bus.alu_src_a     = !rst && alu_src_a;
  assign bus.alu_src_b     = rst ? 2'b00 : alu_src_b;
  assign bus.alu_op        = rst ? 2'b00 : alu_op;
  assign bus.instr_done    = !rst && instr_done;
  assign bus.illegal_op    = !rst && illegal_op;
  assign bus.state         = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle pushes the expected
// output vector (hand-listed state sequence, per-state outputs from the control
// table); a monitor pops and compares on every falling edge.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [21:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // {state, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
  //  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
  //  instr_done, illegal_op}
  function automatic logic [21:0] exp_vec(input logic [3:0] s, input logic mr,
                                          input logic ill, input logic r);
    logic pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, asa, idn;
    logic [1:0] ps, asb, aop;
    {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, asa, idn} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    if (!r) begin
      case (s)
        4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
        4'd1:  asb = 2'b11;
        4'd2:  begin asa = 1; asb = 2'b10; end
        4'd3:  begin mrd = 1; io = 1; end
        4'd4:  begin rw = 1; m2r = 1; idn = 1; end
        4'd5:  begin mwr = 1; io = 1; idn = mr; end
        4'd6:  begin asa = 1; aop = 2'b10; end
        4'd7:  begin rw = 1; rd = 1; idn = 1; end
        4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; idn = 1; end
        4'd9:  begin asa = 1; asb = 2'b10; end
        4'd10: begin rw = 1; idn = 1; end
        4'd11: begin pw = 1; ps = 2'b10; idn = 1; end
        default: ;
      endcase
    end
    return {(r ? 4'd0 : s), pw, pwc, ps, io, mrd, mwr, irw, rd, m2r, rw, asa,
            asb, aop, idn, (r ? 1'b0 : ill)};
  endfunction

  // One stimulus cycle: drive inputs, record expected outputs, advance.
  task automatic step(input string name, input logic r, input logic [5:0] opc,
                      input logic mr, input logic [3:0] s, input logic ill);
    exp_t e;
    rst = r;
    bus.opcode = opc;
    bus.mem_ready = mr;
    e.name = name;
    e.v = exp_vec(s, mr, ill, r);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample mid-cycle, compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e = q.pop_front();
      act = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_source,
             bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
             bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
             bus.alu_op, bus.instr_done, bus.illegal_op};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] ILL = 6'b111111;

  initial begin
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset held for 3 cycles: everything zero.
    for (int i = 0; i < 3; i++) step("reset", 1, 6'd0, 1, 4'd0, 0);
    // First cycle after release: fetch request with no memory yet.
    step("first_fetch_wait", 0, LW, 0, 4'd0, 0);
    // lw
    step("lw_fetch",  0, LW, 1, 4'd0, 0);
    step("lw_decode", 0, LW, 1, 4'd1, 0);
    step("lw_memadr", 0, LW, 1, 4'd2, 0);
    step("lw_memrd",  0, LW, 1, 4'd3, 0);
    step("lw_memwb",  0, LW, 1, 4'd4, 0);
    // sw with two wait cycles in MEMWR
    step("sw_fetch",  0, SW, 1, 4'd0, 0);
    step("sw_decode", 0, SW, 1, 4'd1, 0);
    step("sw_memadr", 0, SW, 1, 4'd2, 0);
    step("sw_wait0",  0, SW, 0, 4'd5, 0);
    step("sw_wait1",  0, SW, 0, 4'd5, 0);
    step("sw_done",   0, SW, 1, 4'd5, 0);
    // beq then R-type
    step("beq_fetch",  0, BEQ, 1, 4'd0, 0);
    step("beq_decode", 0, BEQ, 1, 4'd1, 0);
    step("beq_branch", 0, BEQ, 1, 4'd8, 0);
    step("r_fetch",    0, RT, 1, 4'd0, 0);
    step("r_decode",   0, RT, 1, 4'd1, 0);
    step("r_exec",     0, RT, 1, 4'd6, 0);
    step("r_rwb",      0, RT, 1, 4'd7, 0);
    // illegal opcode
    step("ill_fetch",  0, ILL, 1, 4'd0, 0);
    step("ill_decode", 0, ILL, 1, 4'd1, 1);
    // addi with one fetch wait cycle
    step("addi_fwait",  0, ADDI, 0, 4'd0, 0);
    step("addi_fetch",  0, ADDI, 1, 4'd0, 0);
    step("addi_decode", 0, ADDI, 1, 4'd1, 0);
    step("addi_ex",     0, ADDI, 1, 4'd9, 0);
    step("addi_wb",     0, ADDI, 1, 4'd10, 0);
    // jump
    step("j_fetch",  0, J, 1, 4'd0, 0);
`ifdef MC_CTRL_JUMP_EN
    step("j_decode", 0, J, 1, 4'd1, 0);
    step("j_jump",   0, J, 1, 4'd11, 0);
`else
    step("j_decode_ill", 0, J, 1, 4'd1, 1);
`endif
    // reset during MEMRD aborts the load
    step("abort_fetch",  0, LW, 1, 4'd0, 0);
    step("abort_decode", 0, LW, 1, 4'd1, 0);
    step("abort_memadr", 0, LW, 1, 4'd2, 0);
    step("abort_memrd",  0, LW, 0, 4'd3, 0);
    step("abort_rst",    1, LW, 1, 4'd0, 0);
    step("abort_after",  0, LW, 0, 4'd0, 0);
    step("abort_after2", 0, LW, 0, 4'd0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control unit for the MIPS-subset processor. Sequences a shared-memory, shared-ALU datapath through fetch, decode, execute, memory and write-back states, one instruction at a time. Waits on a memory-ready handshake and flags unsupported opcodes. Sits beside the datapath and drives every register-enable and mux select from the current state.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instr[31:26] from instruction register
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero (beq)
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `iord`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register: 0 rt, 1 rd
- `mem_to_reg`  out  1  write data: 0 ALUOut, 1 MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 PC, 1 register A
- `alu_src_b`  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `alu_op`  out  2  00 add, 01 subtract, 10 decode funct
- `instr_done`  out  1  one-cycle pulse on final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `state`  out  4  current state encoding (debug/bench)

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.

Per-state outputs (unlisted outputs are 0):
- FETCH: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE: alu_src_b=11.
  - Dispatch on opcode: 100011/101011→MEMADR, 000000→EXEC, 000100→BRANCH, 001000→ADDIEX, 000010→JUMP.
  - Any other opcode→FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMRD if opcode=100011, otherwise MEMWR.
- MEMRD: mem_read=1, iord=1. Goes to MEMWB when mem_ready=1.
- MEMWB: reg_write=1, mem_to_reg=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_write=1, iord=1, instr_done=mem_ready. Goes to FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_op=10. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Goes to ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.

Output-derivation rule:
- Outputs are combinational from `state`, plus `mem_ready` where listed above.
- No output is registered.

## Timing
- Reset: while rst=1, state←FETCH on each edge and every output is forced to 0. The state output reads 0.
- First fetch request (mem_read=1) appears in the first cycle after rst deasserts.
- Cycles per instruction with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
  - Request signals stay asserted and stable while waiting.
  - ir_write and pc_write are never asserted during a wait cycle.
- mem_ready is ignored in all other states.
- rst asserted mid-instruction aborts it at the next edge. No write strobe is asserted in the reset cycle.
- `opcode` must remain stable from DECODE through the final cycle of the instruction; the instruction register guarantees this.

## Configuration
- `MC_CTRL_JUMP_EN` defined: opcode 000010 dispatches to JUMP as described.
- `MC_CTRL_JUMP_EN` undefined:
  - JUMP state is never entered.
  - Opcode 000010 is treated as illegal: DECODE→FETCH with illegal_op=1.
  - Encoding 11 is unreachable.

## Test plan
- Reset: hold rst=1 for 3 cycles → state=0 and all outputs 0. First cycle after release → mem_read=1, alu_src_b=01, state=0.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4. reg_write=1 and mem_to_reg=1 only in state 4. instr_done pulses once. 5 cycles total.
- sw (101011) with mem_ready=0 for 2 cycles in MEMWR → states 0,1,2,5,5,5,0. mem_write=1 for 3 cycles; instr_done only on the third.
- beq (000100) then R-type (000000), mem_ready=1:
  - beq → states 0,1,8, with pc_write_cond=1 and pc_source=01 in state 8.
  - R-type → states 0,1,6,7, with reg_dst=1 in state 7.
- Illegal opcode 111111 → states 0,1,0. illegal_op pulses in state 1; no reg_write, mem_write or pc_write asserted.
- j (000010):
  - With MC_CTRL_JUMP_EN: states 0,1,11, pc_write=1, pc_source=10.
  - Without it: states 0,1,0 with illegal_op=1.
  - Separately: rst=1 during MEMRD → state=0 next cycle, with no reg_write.
